// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the clk_sys domain and
// emits framed left/right sample pairs with lock and framing-error status.
module i2s_rx #(
  parameter int AUDIO_DW       = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_err
);
  localparam int CW = $clog2(AUDIO_DW + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX  = CW'(AUDIO_DW + 1);
  localparam logic [CW-1:0] CLAST = CW'(AUDIO_DW - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

  logic [1:0]          rst_q;
  logic                rst_i;
  logic [2:0]          sclk_q;
  logic [1:0]          lr_q;
  logic [1:0]          sd_q;
  logic                rise_d;
  logic                ws_d;
  logic                sd_d;
  logic [AUDIO_DW-1:0] sr;
  logic [AUDIO_DW-1:0] held;
  logic [AUDIO_DW-1:0] word;
  logic [CW-1:0]       bit_cnt;
  logic [TW-1:0]       tmo;
  logic                ws_prev;
  logic                aligned;
  logic                left_ok;
  logic                good;

  // Assert asynchronously, release on clk_sys.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];

  always_ff @(posedge clk_sys or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      lr_q   <= '0;
      sd_q   <= '0;
      rise_d <= 1'b0;
      ws_d   <= 1'b0;
      sd_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      lr_q   <= {lr_q[0], lrclk};
      sd_q   <= {sd_q[0], sdata};
      rise_d <= sclk_q[1] & ~sclk_q[2];
      ws_d   <= lr_q[1];
      sd_d   <= sd_q[1];
    end
  end

  assign word = {sr[AUDIO_DW-2:0], sd_d};
  assign good = aligned && (bit_cnt == CLAST);

  always_ff @(posedge clk_sys or posedge rst_i) begin
    if (rst_i) begin
      sr           <= '0;
      held         <= '0;
      bit_cnt      <= '0;
      tmo          <= '0;
      ws_prev      <= 1'b0;
      aligned      <= 1'b0;
      left_ok      <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise_d) begin
        tmo     <= '0;
        sr      <= word;
        ws_prev <= ws_d;
        if (ws_d != ws_prev) begin
          bit_cnt <= '0;
          aligned <= 1'b1;
          // The first boundary after alignment loss only aligns.
          if (aligned) begin
            if (!good) begin
              left_ok <= 1'b0;
              if (locked) begin
                frame_err <= 1'b1;
                locked    <= 1'b0;
              end
            end else if (!ws_prev) begin
              held    <= word;
              left_ok <= 1'b1;
            end else begin
              left_ok <= 1'b0;
              if (left_ok) begin
                left_chan    <= held;
                right_chan   <= word;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
              end
            end
          end
        end else if (bit_cnt != CMAX) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (tmo != TMAX) begin
        tmo <= tmo + 1'b1;
        if (tmo == TMAX - 1'b1) begin
          locked  <= 1'b0;
          aligned <= 1'b0;
          left_ok <= 1'b0;
        end
      end
    end
  end
endmodule
